// File: rtl/syst_node_cplx_if.sv
// ----------------------------------------------------------------------------
// syst_node_cplx_if
// Groups every non-clock, non-reset signal of one complex systolic MAC node.
//   enable, conj_i, w_load, clr_ovf        : control into the node
//   w_re_i/w_im_i  -> w_re_o/w_im_o        : weight shift chain
//   x_re_i/x_im_i/valid_x_i -> *_o         : sample path, forwarded east
//   psum_re_i/psum_im_i/valid_psumm_i      : partial sum in (aligned with x)
//   psum_re_o/psum_im_o/valid_o            : partial sum out, south
//   ovf_o                                  : sticky overflow flag
// The slave modport is the node's view; the master modport is the driver's.
// ----------------------------------------------------------------------------
interface syst_node_cplx_if #(
    parameter int X_WIDTH  = 16,
    parameter int W_WIDTH  = 16,
    parameter int SI_WIDTH = 32,
    parameter int SO_WIDTH = 32
);
    logic                       enable;
    logic                       conj_i;
    logic                       w_load;
    logic                       clr_ovf;
    logic signed [W_WIDTH-1:0]  w_re_i;
    logic signed [W_WIDTH-1:0]  w_im_i;
    logic signed [W_WIDTH-1:0]  w_re_o;
    logic signed [W_WIDTH-1:0]  w_im_o;
    logic signed [X_WIDTH-1:0]  x_re_i;
    logic signed [X_WIDTH-1:0]  x_im_i;
    logic                       valid_x_i;
    logic signed [X_WIDTH-1:0]  x_re_o;
    logic signed [X_WIDTH-1:0]  x_im_o;
    logic                       valid_x_o;
    logic signed [SI_WIDTH-1:0] psum_re_i;
    logic signed [SI_WIDTH-1:0] psum_im_i;
    logic                       valid_psumm_i;
    logic signed [SO_WIDTH-1:0] psum_re_o;
    logic signed [SO_WIDTH-1:0] psum_im_o;
    logic                       valid_o;
    logic                       ovf_o;

    modport slave (
        input  enable, conj_i, w_load, clr_ovf,
        input  w_re_i, w_im_i, x_re_i, x_im_i, valid_x_i,
        input  psum_re_i, psum_im_i, valid_psumm_i,
        output w_re_o, w_im_o, x_re_o, x_im_o, valid_x_o,
        output psum_re_o, psum_im_o, valid_o, ovf_o
    );

    modport master (
        output enable, conj_i, w_load, clr_ovf,
        output w_re_i, w_im_i, x_re_i, x_im_i, valid_x_i,
        output psum_re_i, psum_im_i, valid_psumm_i,
        input  w_re_o, w_im_o, x_re_o, x_im_o, valid_x_o,
        input  psum_re_o, psum_im_o, valid_o, ovf_o
    );
endinterface

// File: rtl/syst_node_cplx.sv
// ----------------------------------------------------------------------------
// syst_node_cplx
// Complex-valued systolic MAC node: psum_o = psum_i + round(x * w' >> SHIFT),
// w' = conj(w) when conj_i is high. Two pipeline stages (products, then
// combine/round/accumulate/saturate), shift-chain weight loading, sticky
// overflow flag. x is forwarded east after one cycle, psum goes south after two.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, clears every register
//   bus  : syst_node_cplx_if.slave carrying all data/control signals
// ----------------------------------------------------------------------------
module syst_node_cplx #(
    parameter int X_WIDTH  = 16,
    parameter int W_WIDTH  = 16,
    parameter int SI_WIDTH = 32,
    parameter int SO_WIDTH = 32,
    parameter int SHIFT    = 0,
    parameter int SAT      = 1
) (
    input  logic              clk,
    input  logic              rst,
    syst_node_cplx_if.slave   bus
);
    // Products live in SW bits: X+W holds any single product exactly, the two
    // extra bits absorb the re/im add/subtract and the rounding constant.
    localparam int SW = X_WIDTH + W_WIDTH + 2;
    // Accumulation width: wide enough for the shifted product plus psum with
    // no loss, so the overflow test sees the true mathematical sum.
    localparam int TW = ((SW > SO_WIDTH) ? SW : SO_WIDTH) + 2;
    localparam logic signed [TW-1:0] SO_MAX = (TW'(1) <<< (SO_WIDTH - 1)) - TW'(1);
    localparam logic signed [TW-1:0] SO_MIN = ~SO_MAX;

    logic signed [W_WIDTH-1:0]  w_re_q, w_im_q;
    logic signed [X_WIDTH-1:0]  x_re_q, x_im_q;
    logic                       valid_x_q;
    logic signed [SW-1:0]       rr_q, ii_q, ri_q, ir_q;
    logic signed [SI_WIDTH-1:0] p1_q [2];
    logic                       v1_q;
    logic signed [SO_WIDTH-1:0] psum_q [2];
    logic                       valid_q;
    logic                       ovf_q;

    // ---------------- stage 1 operands ----------------
    logic signed [SW-1:0] xr_e, xi_e, wr_e, wi_e;
    logic                 fire1;

    always_comb begin
        xr_e  = SW'(bus.x_re_i);
        xi_e  = SW'(bus.x_im_i);
        wr_e  = SW'(w_re_q);
        // Negation happens after widening so -(-2^(W-1)) is representable.
        wi_e  = bus.conj_i ? -SW'(w_im_q) : SW'(w_im_q);
        fire1 = bus.enable & bus.valid_x_i & bus.valid_psumm_i;
    end

    // ---------------- stage 2 per component (0 = re, 1 = im) ----------------
    logic signed [SW-1:0]       full_c [2];
    logic signed [SO_WIDTH-1:0] res_c  [2];
    logic                       ovf_c  [2];

    assign full_c[0] = rr_q - ii_q;
    assign full_c[1] = ri_q + ir_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_comp
            logic signed [SW-1:0] shifted;
            logic signed [TW-1:0] sum;
            logic                 over_hi, over_lo;

            if (SHIFT > 0) begin : g_rnd
                // Round-half-up: bias by half an LSB, then floor via >>>.
                localparam logic signed [SW-1:0] RND = SW'(1) <<< (SHIFT - 1);
                assign shifted = (full_c[gi] + RND) >>> SHIFT;
            end else begin : g_nornd
                assign shifted = full_c[gi];
            end

            assign sum     = TW'(shifted) + TW'(p1_q[gi]);
            assign over_hi = (sum > SO_MAX);
            assign over_lo = (sum < SO_MIN);
            assign ovf_c[gi] = over_hi | over_lo;

            if (SAT != 0) begin : g_sat
                assign res_c[gi] = over_hi ? SO_MAX[SO_WIDTH-1:0] :
                                   over_lo ? SO_MIN[SO_WIDTH-1:0] :
                                             sum[SO_WIDTH-1:0];
            end else begin : g_wrap
                assign res_c[gi] = sum[SO_WIDTH-1:0];
            end
        end
    endgenerate

    // ---------------- registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_re_q    <= '0;
            w_im_q    <= '0;
            x_re_q    <= '0;
            x_im_q    <= '0;
            valid_x_q <= 1'b0;
            rr_q      <= '0;
            ii_q      <= '0;
            ri_q      <= '0;
            ir_q      <= '0;
            v1_q      <= 1'b0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                p1_q[i]   <= '0;
                psum_q[i] <= '0;
            end
        end else if (bus.enable) begin
            if (bus.w_load) begin
                w_re_q <= bus.w_re_i;
                w_im_q <= bus.w_im_i;
            end

            valid_x_q <= bus.valid_x_i;
            if (bus.valid_x_i) begin
                x_re_q <= bus.x_re_i;
                x_im_q <= bus.x_im_i;
            end

            v1_q <= fire1;
            if (fire1) begin
                rr_q    <= xr_e * wr_e;
                ii_q    <= xi_e * wi_e;
                ri_q    <= xr_e * wi_e;
                ir_q    <= xi_e * wr_e;
                p1_q[0] <= bus.psum_re_i;
                p1_q[1] <= bus.psum_im_i;
            end

            valid_q <= v1_q;
            if (v1_q) begin
                psum_q[0] <= res_c[0];
                psum_q[1] <= res_c[1];
            end

            // A fresh overflow outranks a clear arriving on the same edge.
            if (v1_q && (ovf_c[0] || ovf_c[1]))
                ovf_q <= 1'b1;
            else if (bus.clr_ovf)
                ovf_q <= 1'b0;
        end
    end

    assign bus.w_re_o    = w_re_q;
    assign bus.w_im_o    = w_im_q;
    assign bus.x_re_o    = x_re_q;
    assign bus.x_im_o    = x_im_q;
    assign bus.valid_x_o = valid_x_q;
    assign bus.psum_re_o = psum_q[0];
    assign bus.psum_im_o = psum_q[1];
    assign bus.valid_o   = valid_q;
    assign bus.ovf_o     = ovf_q;
endmodule

// File: tb/tb_syst_node_cplx.sv
// ----------------------------------------------------------------------------
// tb_syst_node_cplx
// Bench for syst_node_cplx. dut0 (SHIFT=0, SAT=1) is the main node and heads a
// three-node weight chain (dut_c1, dut_c2). dut_s (SHIFT=2) covers rounding.
// dut0 results are predicted from a complex-arithmetic model and queued when a
// firing sample is driven; they are popped when dut0 presents a new output.
// ----------------------------------------------------------------------------
module tb_syst_node_cplx;
    localparam int XW  = 16;
    localparam int WW  = 16;
    localparam int SIW = 32;
    localparam int SOW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    syst_node_cplx_if #(.X_WIDTH(XW), .W_WIDTH(WW), .SI_WIDTH(SIW), .SO_WIDTH(SOW)) if0 ();
    syst_node_cplx_if #(.X_WIDTH(XW), .W_WIDTH(WW), .SI_WIDTH(SIW), .SO_WIDTH(SOW)) ifc1 ();
    syst_node_cplx_if #(.X_WIDTH(XW), .W_WIDTH(WW), .SI_WIDTH(SIW), .SO_WIDTH(SOW)) ifc2 ();
    syst_node_cplx_if #(.X_WIDTH(XW), .W_WIDTH(WW), .SI_WIDTH(SIW), .SO_WIDTH(SOW)) ifs ();

    syst_node_cplx #(.X_WIDTH(XW), .W_WIDTH(WW), .SI_WIDTH(SIW), .SO_WIDTH(SOW),
                     .SHIFT(0), .SAT(1)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    syst_node_cplx #(.X_WIDTH(XW), .W_WIDTH(WW), .SI_WIDTH(SIW), .SO_WIDTH(SOW),
                     .SHIFT(0), .SAT(1)) dut_c1 (.clk(clk), .rst(rst), .bus(ifc1.slave));
    syst_node_cplx #(.X_WIDTH(XW), .W_WIDTH(WW), .SI_WIDTH(SIW), .SO_WIDTH(SOW),
                     .SHIFT(0), .SAT(1)) dut_c2 (.clk(clk), .rst(rst), .bus(ifc2.slave));
    syst_node_cplx #(.X_WIDTH(XW), .W_WIDTH(WW), .SI_WIDTH(SIW), .SO_WIDTH(SOW),
                     .SHIFT(2), .SAT(1)) dut_s (.clk(clk), .rst(rst), .bus(ifs.slave));

    // Chain nodes: weights ripple from dut0, everything else idle.
    assign ifc1.enable = if0.enable;  assign ifc2.enable = if0.enable;
    assign ifc1.w_load = if0.w_load;  assign ifc2.w_load = if0.w_load;
    assign ifc1.w_re_i = if0.w_re_o;  assign ifc2.w_re_i = ifc1.w_re_o;
    assign ifc1.w_im_i = if0.w_im_o;  assign ifc2.w_im_i = ifc1.w_im_o;
    assign ifc1.conj_i = 1'b0;        assign ifc2.conj_i = 1'b0;
    assign ifc1.clr_ovf = 1'b0;       assign ifc2.clr_ovf = 1'b0;
    assign ifc1.x_re_i = '0;          assign ifc2.x_re_i = '0;
    assign ifc1.x_im_i = '0;          assign ifc2.x_im_i = '0;
    assign ifc1.valid_x_i = 1'b0;     assign ifc2.valid_x_i = 1'b0;
    assign ifc1.psum_re_i = '0;       assign ifc2.psum_re_i = '0;
    assign ifc1.psum_im_i = '0;       assign ifc2.psum_im_i = '0;
    assign ifc1.valid_psumm_i = 1'b0; assign ifc2.valid_psumm_i = 1'b0;

    typedef struct { longint re; longint im; } exp_t;
    exp_t   sb_q [$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     n_pop    = 0;
    longint last_re  = 0;
    longint ch_re [3];
    longint ch_im [3];

    // Spec-level reference: psum + round(x*w' >> shift), clamped to SOW bits.
    function automatic void model(input longint xr, input longint xi, input longint wr,
                                  input longint wi, input bit cj, input longint pr,
                                  input longint pi, input int shift,
                                  output longint o_re, output longint o_im, output bit o_ovf);
        longint wi2, re, im, hi, lo, sr, si;
        wi2 = cj ? -wi : wi;
        re  = xr * wr - xi * wi2;
        im  = xr * wi2 + xi * wr;
        if (shift > 0) begin
            re = (re + (longint'(1) <<< (shift - 1))) >>> shift;
            im = (im + (longint'(1) <<< (shift - 1))) >>> shift;
        end
        hi = (longint'(1) <<< (SOW - 1)) - 1;
        lo = -hi - 1;
        sr = pr + re;
        si = pi + im;
        o_ovf = (sr > hi) || (sr < lo) || (si > hi) || (si < lo);
        o_re = (sr > hi) ? hi : (sr < lo) ? lo : sr;
        o_im = (si > hi) ? hi : (si < lo) ? lo : si;
    endfunction

    // One clock; compares dut0 against the scoreboard when it produced a new output.
    task automatic step();
        logic en_edge;
        exp_t e;
        @(posedge clk);
        en_edge = if0.enable;
        @(negedge clk);
        if (en_edge && !rst && if0.valid_o) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: valid_o=1 got (%0d,%0d) but no result expected",
                         if0.psum_re_o, if0.psum_im_o);
            end else begin
                e = sb_q.pop_front();
                n_pop++;
                last_re = e.re;
                if (if0.psum_re_o !== 32'(e.re) || if0.psum_im_o !== 32'(e.im)) begin
                    n_fail++;
                    $display("FAIL sb_psum: got (%0d,%0d) expected (%0d,%0d)",
                             if0.psum_re_o, if0.psum_im_o, e.re, e.im);
                end else
                    $display("sb_psum ok: (%0d,%0d)", e.re, e.im);
            end
        end
    endtask

    task automatic drive(input longint xr, input longint xi, input longint pr, input longint pi,
                         input bit vx, input bit vp, input bit cj);
        exp_t e;
        bit   ov;
        if0.x_re_i = 16'(xr);
        if0.x_im_i = 16'(xi);
        if0.psum_re_i = 32'(pr);
        if0.psum_im_i = 32'(pi);
        if0.valid_x_i = vx;
        if0.valid_psumm_i = vp;
        if0.conj_i = cj;
        if (if0.enable && vx && vp) begin
            model(xr, xi, ch_re[0], ch_im[0], cj, pr, pi, 0, e.re, e.im, ov);
            sb_q.push_back(e);
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load_w(input longint wr, input longint wi);
        if0.w_load = 1'b1;
        if0.w_re_i = 16'(wr);
        if0.w_im_i = 16'(wi);
        step();
        if0.w_load = 1'b0;
        ch_re[2] = ch_re[1]; ch_im[2] = ch_im[1];
        ch_re[1] = ch_re[0]; ch_im[1] = ch_im[0];
        ch_re[0] = wr;       ch_im[0] = wi;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if0.enable = 1'b1; if0.w_load = 1'b0; if0.clr_ovf = 1'b0;
        if0.w_re_i = '0; if0.w_im_i = '0;
        ifs.enable = 1'b1; ifs.w_load = 1'b0; ifs.clr_ovf = 1'b0; ifs.conj_i = 1'b0;
        ifs.w_re_i = '0; ifs.w_im_i = '0; ifs.x_re_i = '0; ifs.x_im_i = '0;
        ifs.valid_x_i = 1'b0; ifs.valid_psumm_i = 1'b0; ifs.psum_re_i = '0; ifs.psum_im_i = '0;
        for (int i = 0; i < 3; i++) begin ch_re[i] = 0; ch_im[i] = 0; end
        idle();
        step(); step();
        n_checks++;
        if ({if0.w_re_o, if0.w_im_o, if0.x_re_o, if0.x_im_o} !== 64'd0) begin
            n_fail++; $display("FAIL reset_w_x: got w=(%0d,%0d) x=(%0d,%0d) expected zeros",
                               if0.w_re_o, if0.w_im_o, if0.x_re_o, if0.x_im_o);
        end
        n_checks++;
        if ({if0.psum_re_o, if0.psum_im_o} !== 64'd0) begin
            n_fail++; $display("FAIL reset_psum: got (%0d,%0d) expected (0,0)",
                               if0.psum_re_o, if0.psum_im_o);
        end
        n_checks++;
        if ({if0.valid_x_o, if0.valid_o, if0.ovf_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000",
                               {if0.valid_x_o, if0.valid_o, if0.ovf_o});
        end
        #2 rst = 1'b0;
        step();
        $display("test_reset done");
    endtask

    task automatic test_weight_chain();
        longint wr_t [3];
        longint wi_t [3];
        wr_t[0] = 7;  wi_t[0] = 1;
        wr_t[1] = -4; wi_t[1] = 9;
        wr_t[2] = 3;  wi_t[2] = -2;
        for (int k = 0; k < 3; k++) begin
            load_w(wr_t[k], wi_t[k]);
            n_checks++;
            if (if0.w_re_o !== 16'(ch_re[0]) || if0.w_im_o !== 16'(ch_im[0]) ||
                ifc1.w_re_o !== 16'(ch_re[1]) || ifc1.w_im_o !== 16'(ch_im[1]) ||
                ifc2.w_re_o !== 16'(ch_re[2]) || ifc2.w_im_o !== 16'(ch_im[2])) begin
                n_fail++;
                $display("FAIL chain_strobe%0d: got (%0d,%0d)(%0d,%0d)(%0d,%0d) expected (%0d,%0d)(%0d,%0d)(%0d,%0d)",
                         k, if0.w_re_o, if0.w_im_o, ifc1.w_re_o, ifc1.w_im_o, ifc2.w_re_o, ifc2.w_im_o,
                         ch_re[0], ch_im[0], ch_re[1], ch_im[1], ch_re[2], ch_im[2]);
            end else
                $display("chain strobe %0d ok", k);
        end
    endtask

    task automatic test_basic();
        drive(5, 7, 100, -50, 1'b1, 1'b1, 1'b0);
        step();
        n_checks++;
        if (if0.valid_o !== 1'b0) begin
            n_fail++; $display("FAIL latency_early: valid_o=%b expected 0 after one cycle", if0.valid_o);
        end
        drive(5, 7, 100, -50, 1'b1, 1'b1, 1'b1);
        step();
        idle();
        step(); step();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++; $display("FAIL basic_drain: %0d results outstanding expected 0", sb_q.size());
        end
    endtask

    task automatic test_one_valid();
        drive(11, -3, 9, 9, 1'b1, 1'b0, 1'b0);
        step();
        n_checks++;
        if (if0.valid_x_o !== 1'b1 || if0.x_re_o !== 16'sd11 || if0.x_im_o !== -16'sd3) begin
            n_fail++; $display("FAIL fwd_x: got v=%b x=(%0d,%0d) expected v=1 x=(11,-3)",
                               if0.valid_x_o, if0.x_re_o, if0.x_im_o);
        end
        drive(0, 0, 5, 5, 1'b0, 1'b1, 1'b0);
        step();
        n_checks++;
        if (if0.valid_o !== 1'b0 || if0.valid_x_o !== 1'b0 || if0.x_re_o !== 16'sd11) begin
            n_fail++; $display("FAIL x_only: got valid_o=%b valid_x_o=%b x_re=%0d expected 0 0 11",
                               if0.valid_o, if0.valid_x_o, if0.x_re_o);
        end
        idle();
        step();
        n_checks++;
        if (if0.valid_o !== 1'b0) begin
            n_fail++; $display("FAIL psum_only: valid_o=%b expected 0", if0.valid_o);
        end
    endtask

    task automatic test_sat();
        load_w(10, -1);
        drive(10, 0, 64'sd2147483638, -64'sd2147483643, 1'b1, 1'b1, 1'b0);
        step(); idle(); step();
        n_checks++;
        if (if0.ovf_o !== 1'b1) begin
            n_fail++; $display("FAIL ovf_set: ovf_o=%b expected 1", if0.ovf_o);
        end
        if0.clr_ovf = 1'b1; step(); if0.clr_ovf = 1'b0;
        n_checks++;
        if (if0.ovf_o !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clr: ovf_o=%b expected 0", if0.ovf_o);
        end
        drive(10, 0, 64'sd2147483638, 0, 1'b1, 1'b1, 1'b0);
        step(); idle();
        if0.clr_ovf = 1'b1; step(); if0.clr_ovf = 1'b0;
        n_checks++;
        if (if0.ovf_o !== 1'b1) begin
            n_fail++; $display("FAIL ovf_set_wins: ovf_o=%b expected 1", if0.ovf_o);
        end
        if0.clr_ovf = 1'b1; step(); if0.clr_ovf = 1'b0;
        load_w(3, -2);
        drive(-300, 1000, 123, 456, 1'b1, 1'b1, 1'b1);
        step(); idle(); step();
        n_checks++;
        if (if0.ovf_o !== 1'b0) begin
            n_fail++; $display("FAIL ovf_spurious: ovf_o=%b expected 0", if0.ovf_o);
        end
    endtask

    task automatic test_stall();
        int pops0;
        pops0 = n_pop;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                if0.enable = 1'b0;
                drive(1, 1, 1, 1, 1'b1, 1'b1, 1'b0);
                for (int s = 0; s < 3; s++) begin
                    step();
                    n_checks++;
                    if (if0.valid_o !== 1'b1 || if0.psum_re_o !== 32'(last_re)) begin
                        n_fail++; $display("FAIL stall_hold%0d: got v=%b re=%0d expected v=1 re=%0d",
                                           s, if0.valid_o, if0.psum_re_o, last_re);
                    end
                end
                if0.enable = 1'b1;
            end
            drive(longint'($urandom_range(0, 65535)) - 32768, longint'($urandom_range(0, 65535)) - 32768,
                  longint'($urandom_range(0, 32'h3FFF_FFFF)) - 64'sd536870912,
                  longint'($urandom_range(0, 32'h3FFF_FFFF)) - 64'sd536870912,
                  1'b1, 1'b1, 1'($urandom_range(0, 1)));
            step();
        end
        idle();
        step(); step(); step();
        n_checks++;
        if (n_pop - pops0 != 8 || sb_q.size() != 0) begin
            n_fail++; $display("FAIL stall_count: got %0d outputs, %0d left expected 8, 0",
                               n_pop - pops0, sb_q.size());
        end
    endtask

    task automatic test_shift();
        longint er, ei;
        bit     ov;
        ifs.w_load = 1'b1; ifs.w_re_i = 16'sd1; ifs.w_im_i = 16'sd0;
        step();
        ifs.w_load = 1'b0;
        ifs.x_re_i = 16'sd6; ifs.x_im_i = -16'sd6;
        ifs.valid_x_i = 1'b1; ifs.valid_psumm_i = 1'b1;
        step();
        ifs.x_re_i = 16'sd2; ifs.x_im_i = -16'sd2;
        step();
        ifs.valid_x_i = 1'b0; ifs.valid_psumm_i = 1'b0;
        model(6, -6, 1, 0, 1'b0, 0, 0, 2, er, ei, ov);
        n_checks++;
        if (ifs.valid_o !== 1'b1 || ifs.psum_re_o !== 32'(er) || ifs.psum_im_o !== 32'(ei)) begin
            n_fail++; $display("FAIL shift_1p5: got v=%b (%0d,%0d) expected v=1 (%0d,%0d)",
                               ifs.valid_o, ifs.psum_re_o, ifs.psum_im_o, er, ei);
        end else $display("shift 1.5 ok: (%0d,%0d)", er, ei);
        step();
        model(2, -2, 1, 0, 1'b0, 0, 0, 2, er, ei, ov);
        n_checks++;
        if (ifs.valid_o !== 1'b1 || ifs.psum_re_o !== 32'(er) || ifs.psum_im_o !== 32'(ei)) begin
            n_fail++; $display("FAIL shift_0p5: got v=%b (%0d,%0d) expected v=1 (%0d,%0d)",
                               ifs.valid_o, ifs.psum_re_o, ifs.psum_im_o, er, ei);
        end else $display("shift 0.5 ok: (%0d,%0d)", er, ei);
    endtask

    task automatic test_reset_midstream();
        drive(100, -200, 7, 8, 1'b1, 1'b1, 1'b0);
        step();
        drive(-5, 9, 1, 2, 1'b1, 1'b1, 1'b1);
        step();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({if0.valid_o, if0.valid_x_o, if0.ovf_o} !== 3'b000 ||
            {if0.psum_re_o, if0.psum_im_o, if0.x_re_o, if0.w_re_o} !== 96'd0) begin
            n_fail++; $display("FAIL rst_mid: got v=%b vx=%b psum=(%0d,%0d) x=%0d w=%0d expected all 0",
                               if0.valid_o, if0.valid_x_o, if0.psum_re_o, if0.psum_im_o,
                               if0.x_re_o, if0.w_re_o);
        end
        sb_q.delete();
        for (int i = 0; i < 3; i++) begin ch_re[i] = 0; ch_im[i] = 0; end
        idle();
        #1 rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            n_checks++;
            if (if0.valid_o !== 1'b0) begin
                n_fail++; $display("FAIL rst_stale%0d: valid_o=%b expected 0", s, if0.valid_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_weight_chain();
        test_basic();
        test_one_valid();
        test_sat();
        test_stall();
        test_shift();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
